// File: rtl/lipsi_prog_loader.sv
// lipsi_prog_loader: writes a framed, checksummed byte stream into Lipsi program memory and holds the core in reset until a load verifies
module lipsi_prog_loader #(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 8,
  parameter int BASE_ADDR = 0
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_in_valid,
  input  logic [DATA_W-1:0] i_in_data,
  output logic              o_in_ready,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  output logic              o_cpu_reset,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_error,
  output logic [ADDR_W:0]   o_word_count
);
  typedef enum logic [2:0] {S_IDLE, S_LEN, S_DATA, S_CSUM, S_DONE, S_ERR} state_t;
  localparam logic [ADDR_W-1:0] L_BASE = ADDR_W'(BASE_ADDR);
  state_t              r_state, w_next;
  logic                r_in_ready, r_mem_we, r_cpu_reset, r_busy, r_done, r_error;
  logic [ADDR_W-1:0]   r_mem_addr, r_addr;
  logic [DATA_W-1:0]   r_mem_wdata, r_sum, r_rem;
  logic [ADDR_W:0]     r_word_count;
  logic                w_xfer, w_start, w_sum_ok;
  assign w_xfer   = i_in_valid & r_in_ready;
  assign w_start  = i_start & (r_state == S_IDLE || r_state == S_DONE || r_state == S_ERR);
  assign w_sum_ok = (r_sum + i_in_data) == '0;
  // next-state decode; start is only honoured while not loading
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE, S_ERR: w_next = i_start ? S_LEN : r_state;
      S_LEN:  w_next = !w_xfer ? S_LEN : (i_in_data == '0 ? S_ERR : S_DATA);
      S_DATA: w_next = (w_xfer && r_rem == DATA_W'(1)) ? S_CSUM : S_DATA;
      S_CSUM: w_next = !w_xfer ? S_CSUM : (w_sum_ok ? S_DONE : S_ERR);
      default: w_next = S_IDLE;
    endcase
  end
  // state, registered handshake/status outputs and one-cycle-late memory write
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= S_IDLE;
      r_in_ready   <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= L_BASE;
      r_mem_wdata  <= '0;
      r_cpu_reset  <= 1'b1;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
      r_word_count <= '0;
      r_addr       <= L_BASE;
      r_sum        <= '0;
      r_rem        <= '0;
    end else begin
      r_state    <= w_next;
      r_in_ready <= (w_next == S_LEN || w_next == S_DATA || w_next == S_CSUM);
      r_mem_we   <= (r_state == S_DATA) && w_xfer;
      if (w_start) begin
        r_busy       <= 1'b1;
        r_done       <= 1'b0;
        r_error      <= 1'b0;
        r_cpu_reset  <= 1'b1;
        r_word_count <= '0;
        r_addr       <= L_BASE;
        r_sum        <= '0;
      end
      if (r_state == S_LEN && w_xfer) begin
        r_rem <= i_in_data;
        if (i_in_data == '0) begin
          r_busy  <= 1'b0;
          r_error <= 1'b1;
        end
      end
      if (r_state == S_DATA && w_xfer) begin
        r_mem_addr   <= r_addr;
        r_mem_wdata  <= i_in_data;
        r_addr       <= r_addr + ADDR_W'(1);
        r_word_count <= r_word_count + (ADDR_W+1)'(1);
        r_sum        <= r_sum + i_in_data;
        r_rem        <= r_rem - DATA_W'(1);
      end
      if (r_state == S_CSUM && w_xfer) begin
        r_busy      <= 1'b0;
        r_done      <= w_sum_ok;
        r_error     <= !w_sum_ok;
        r_cpu_reset <= !w_sum_ok;
      end
    end
  end
  assign o_in_ready   = r_in_ready;
  assign o_mem_we     = r_mem_we;
  assign o_mem_addr   = r_mem_addr;
  assign o_mem_wdata  = r_mem_wdata;
  assign o_cpu_reset  = r_cpu_reset;
  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_error      = r_error;
  assign o_word_count = r_word_count;
endmodule

// File: doc/lipsi_prog_loader.md
Name: lipsi_prog_loader

Overview:
- Program-memory writer for the Lipsi processor. The processor core only reads program memory.
- This block accepts a framed byte stream over a valid/ready interface and writes each payload byte into program memory.
- Holds the core in reset for the whole load. Releases the core only after the frame checksum verifies.
- Sits between the host/debug byte source and the lipsi_processor instruction memory write port and reset input.

Parameters:
- ADDR_W, 8, program memory address width.
- DATA_W, 8, byte width. Fixed at 8; other values unsupported.
- BASE_ADDR, 0, first memory address written.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to begin a load.
- in_valid  in  1  source byte valid.
- in_data  in  8  source byte.
- in_ready  out  1  loader accepts a byte this cycle.
- mem_we  out  1  program memory write enable.
- mem_addr  out  ADDR_W  write address.
- mem_wdata  out  8  write data.
- cpu_reset  out  1  active-high reset to lipsi_processor.
- busy  out  1  load in progress.
- done  out  1  last load succeeded (level).
- error  out  1  last load failed (level).
- word_count  out  ADDR_W+1  payload bytes written in the current or last load.

Behaviour:
- Reset (reset=0, async):
  - FSM enters IDLE.
  - in_ready=0, mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, busy=0, done=0, error=0, word_count=0.
  - cpu_reset=1. The core stays held until the first successful load.
- Frame format:
  - LEN byte N, with 1..255 valid.
  - N payload bytes.
  - CSUM byte. Frame is valid when (sum of payload + CSUM) mod 256 == 0.
- Handshake:
  - A byte transfers on a rising edge with in_valid=1 and in_ready=1.
  - in_ready is a registered level: 1 in LEN, DATA and CSUM; 0 elsewhere.
  - The source may hold in_valid high indefinitely. Zero-bubble back-to-back transfers are supported.
- FSM states: IDLE, LEN, DATA, CSUM, DONE, ERR.
  - IDLE/DONE/ERR + start=1 → LEN. On this transition: busy=1, done=0, error=0, cpu_reset=1, word_count=0, address counter=BASE_ADDR, sum=0.
  - LEN + transfer:
    - If in_data==0 → ERR.
    - Otherwise latch N and go to DATA.
  - DATA + transfer:
    - Next cycle, mem_we=1 for exactly one cycle, with mem_addr=current counter and mem_wdata=byte (write latency 1 cycle).
    - Counter increments, word_count increments, sum += byte (mod 256).
    - After the Nth byte → CSUM.
  - CSUM + transfer:
    - If (sum+in_data)[7:0]==0 → DONE: busy=0, done=1, and cpu_reset=0 on the next cycle.
    - Otherwise → ERR: busy=0, error=1, cpu_reset stays 1.
  - start while busy=1 is ignored.
- Address arithmetic: mem_addr = BASE_ADDR + index, wrapping modulo 2^ADDR_W. No saturation.
- Simultaneous events:
  - In DONE, start=1 → LEN. cpu_reset re-asserts on the following cycle, so the core is held before any write.
  - Asynchronous reset mid-frame aborts the load: no further mem_we, cpu_reset=1, all state as at reset. A partially written memory is left as is.
- mem_we is never asserted outside the cycle after a DATA transfer.

Test Plan:
- Basic load: reset low 2 cycles then high; start; stream 03,10,20,30,A0 with in_valid held high.
  - mem_we pulses at addr 0,1,2 with data 10,20,30 on consecutive cycles.
  - Then done=1, error=0, word_count=3, cpu_reset falls one cycle after the CSUM transfer.
- Back-pressure/gaps: same frame with in_valid toggling 1,0,0,1…
  - Identical writes. No write occurs on gap cycles. in_ready stays 1 throughout.
- Bad checksum: 02,01,02,00.
  - Writes to addr 0,1 occur, then error=1, done=0, cpu_reset stays 1.
- Zero length: start, LEN=00.
  - No mem_we, error=1, busy=0, in_ready=0.
- Reload and abort:
  - After a successful load, start again: cpu_reset=1 within 1 cycle.
  - Drive reset low after the 2nd payload byte: outputs return to reset values immediately, and no mem_we follows.
- Wrap: BASE_ADDR=254, LEN=03, payload 01,02,03, CSUM FA.
  - Writes land at addr 254,255,0.
  - done=1, word_count=3.
